// File: rtl/minirisc_pkg.sv
// Shared definitions for the miniRISC memory arbiter: FSM state codes, port selectors, helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package minirisc_pkg;

   // FSM state encoding for the arbiter access sequence
   typedef logic [1:0] state_t;
   localparam state_t S_IDLE   = 2'd0;
   localparam state_t S_ACCESS = 2'd1;
   localparam state_t S_WAIT   = 2'd2;
   localparam state_t S_RESP   = 2'd3;

   // Which requester owns the current access
   localparam logic SEL_IF = 1'b0;
   localparam logic SEL_DM = 1'b1;

   // Streak counter width; large enough for the widest legal streak limit (15)
   localparam int STREAK_W = 4;

   // Saturating increment: stops at lim instead of wrapping
   function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] val,
                                                   input logic [STREAK_W-1:0] lim);
      logic [STREAK_W-1:0] res;
      res = (val >= lim) ? lim : val + 1'b1;
      return res;
   endfunction

endpackage

// File: rtl/minirisc_mem_arbiter_sel.sv
// Winner select between IF and DM with a DM-priority streak limit that guarantees IF progress.
// Latency: sel is combinational from the requests; streak updates on the clock edge of a grant.
// Backpressure: none; the parent only consumes sel when arb_en is high.
module mem_arb_sel
   import minirisc_pkg::*;
#(
   parameter int MAX_STREAK = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic if_req,
   input  logic dm_req,
   input  logic arb_en,
   output logic sel
);

   localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(MAX_STREAK);

   // Number of consecutive DM wins that happened while IF was also waiting
   logic [STREAK_W-1:0] streak;
   logic                streak_full;

   assign streak_full = (streak == STREAK_LIM);

   // DM wins by default; IF wins when alone or when DM has used up its streak
   always_comb begin
      sel = SEL_IF;
      if (dm_req && !(if_req && streak_full)) begin
         sel = SEL_DM;
      end
   end

   // Streak bookkeeping: only a contended DM grant extends it, anything else clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         streak <= '0;
      end else if (arb_en) begin
         if (sel == SEL_DM && if_req) begin
            streak <= sat_inc(streak, STREAK_LIM);
         end else begin
            streak <= '0;
         end
      end
   end

endmodule

// File: rtl/minirisc_mem_arbiter.sv
// Shares one single-port synchronous memory between miniRISC instruction fetch and data ports.
// Latency: sample in IDLE at T -> gnt/mem_en at T+1 -> rvalid at T+2+RD_LAT; writes finish at T+2.
// Backpressure: one access outstanding; requests are only sampled in IDLE and must be held until gnt.
module minirisc_mem_arbiter
   import minirisc_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 1,
   parameter int MAX_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   // instruction-fetch port (read only)
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   // data-memory port
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   // memory side
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   // status
   output logic              busy
);

   // Countdown loaded on a read so WAIT ends exactly when mem_rdata becomes valid
   localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

   state_t              state;
   state_t              state_nxt;
   logic                arb_en;
   logic                sel;
   logic [1:0]          cnt;
   logic                cnt_zero;

   // Latched winner and its access; these also drive mem_* so they hold between accesses
   logic                lat_sel;
   logic                lat_we;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;

   logic [DATA_W-1:0]   if_rdata_q;
   logic [DATA_W-1:0]   dm_rdata_q;

   assign arb_en   = (state == S_IDLE) && (if_req || dm_req);
   assign cnt_zero = (cnt == 2'd0);

   mem_arb_sel #(
      .MAX_STREAK (MAX_STREAK)
   ) u_sel (
      .clk    (clk),
      .rst    (rst),
      .if_req (if_req),
      .dm_req (dm_req),
      .arb_en (arb_en),
      .sel    (sel)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: IDLE -> ACCESS -> IDLE (write) or WAIT -> RESP -> IDLE (read)
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (if_req || dm_req) begin
               state_nxt = S_ACCESS;
            end
         end
         S_ACCESS: begin
            state_nxt = lat_we ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (cnt_zero) begin
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs: mem_en and gnt only in ACCESS, rvalid only in RESP, both steered by the winner
   always_comb begin
      mem_en    = 1'b0;
      if_gnt    = 1'b0;
      dm_gnt    = 1'b0;
      if_rvalid = 1'b0;
      dm_rvalid = 1'b0;
      case (state)
         S_ACCESS: begin
            mem_en = 1'b1;
            if (lat_sel == SEL_DM) begin
               dm_gnt = 1'b1;
            end else begin
               if_gnt = 1'b1;
            end
         end
         S_RESP: begin
            if (lat_sel == SEL_DM) begin
               dm_rvalid = 1'b1;
            end else begin
               if_rvalid = 1'b1;
            end
         end
         default: begin
            mem_en = 1'b0;
         end
      endcase
   end

   // Capture the winner's access in IDLE; IF never writes and keeps the old write data
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_sel   <= SEL_IF;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (arb_en) begin
         lat_sel <= sel;
         if (sel == SEL_DM) begin
            lat_we    <= dm_we;
            lat_addr  <= dm_addr;
            lat_wdata <= dm_wdata;
         end else begin
            lat_we    <= 1'b0;
            lat_addr  <= if_addr;
         end
      end
   end

   // Read latency countdown: loaded in ACCESS, counts down through WAIT
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 2'd0;
      end else if (state == S_ACCESS && !lat_we) begin
         cnt <= CNT_LOAD;
      end else if (state == S_WAIT && !cnt_zero) begin
         cnt <= cnt - 2'd1;
      end
   end

   // Read data registers: only the winner's register loads, the other holds its last response
   always_ff @(posedge clk) begin
      if (rst) begin
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else if (state == S_WAIT && cnt_zero) begin
         if (lat_sel == SEL_DM) begin
            dm_rdata_q <= mem_rdata;
         end else begin
            if_rdata_q <= mem_rdata;
         end
      end
   end

   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign mem_we    = lat_we;
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;
   assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_minirisc_mem_arbiter.sv
// Directed bench for the miniRISC memory arbiter with a response scoreboard.
// Latency: two instances, RD_LAT=1 (a_*) and RD_LAT=3 (b_*), each with its own memory model.
// Backpressure: requests held until gnt, exactly like the core does.
module tb_minirisc_mem_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // instance a: RD_LAT=1
   logic          a_if_req, a_if_gnt, a_if_rvalid;
   logic [AW-1:0] a_if_addr;
   logic [DW-1:0] a_if_rdata;
   logic          a_dm_req, a_dm_we, a_dm_gnt, a_dm_rvalid;
   logic [AW-1:0] a_dm_addr;
   logic [DW-1:0] a_dm_wdata, a_dm_rdata;
   logic          a_mem_en, a_mem_we, a_busy;
   logic [AW-1:0] a_mem_addr;
   logic [DW-1:0] a_mem_wdata, a_mem_rdata;

   // instance b: RD_LAT=3
   logic          b_if_req, b_if_gnt, b_if_rvalid;
   logic [AW-1:0] b_if_addr;
   logic [DW-1:0] b_if_rdata;
   logic          b_dm_req, b_dm_we, b_dm_gnt, b_dm_rvalid;
   logic [AW-1:0] b_dm_addr;
   logic [DW-1:0] b_dm_wdata, b_dm_rdata;
   logic          b_mem_en, b_mem_we, b_busy;
   logic [AW-1:0] b_mem_addr;
   logic [DW-1:0] b_mem_wdata, b_mem_rdata;

   minirisc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_STREAK(4)) dut_a (
      .clk(clk), .rst(rst),
      .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
      .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
      .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
      .dm_gnt(a_dm_gnt), .dm_rvalid(a_dm_rvalid), .dm_rdata(a_dm_rdata),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
   );

   minirisc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .MAX_STREAK(4)) dut_b (
      .clk(clk), .rst(rst),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
      .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
      .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
      .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
   );

   // memory contents as a pure function of address
   function automatic logic [DW-1:0] mval(input logic [AW-1:0] addr);
      if (addr == 10'h010) return 32'hDEADBEEF;
      return 32'hA500_0000 | {22'b0, addr};
   endfunction

   // memory models: data valid exactly RD_LAT cycles after the mem_en cycle, junk otherwise
   logic [DW-1:0] b_p0, b_p1, b_p2;
   always @(posedge clk) begin
      a_mem_rdata <= (a_mem_en && !a_mem_we) ? mval(a_mem_addr) : 32'hBAD0BAD0;
      b_p0 <= (b_mem_en && !b_mem_we) ? mval(b_mem_addr) : 32'hBAD1BAD1;
      b_p1 <= b_p0;
      b_p2 <= b_p1;
   end
   assign b_mem_rdata = b_p2;

   // scoreboard
   typedef struct packed {
      bit            dm;
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   exp_t sb_a[$];
   exp_t sb_b[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // response monitors: every rvalid must match the head of its scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (a_if_rvalid || a_dm_rvalid) begin
         if (sb_a.size() == 0) begin
            chk("a_unexpected_rvalid", {a_if_rvalid, a_dm_rvalid}, 0);
         end else begin
            e = sb_a.pop_front();
            chk("a_rvalid_port", {a_if_rvalid, a_dm_rvalid}, e.dm ? 2'b01 : 2'b10);
            chk("a_rdata", e.dm ? a_dm_rdata : a_if_rdata, e.data);
            if (e.cyc >= 0) chk("a_rvalid_cycle", cyc, e.cyc);
         end
      end
      if (a_if_gnt || a_dm_gnt) chk("a_single_gnt", a_if_gnt & a_dm_gnt, 0);
      if (b_if_rvalid || b_dm_rvalid) begin
         if (sb_b.size() == 0) begin
            chk("b_unexpected_rvalid", {b_if_rvalid, b_dm_rvalid}, 0);
         end else begin
            e = sb_b.pop_front();
            chk("b_rvalid_port", {b_if_rvalid, b_dm_rvalid}, e.dm ? 2'b01 : 2'b10);
            chk("b_rdata", e.dm ? b_dm_rdata : b_if_rdata, e.data);
            if (e.cyc >= 0) chk("b_rvalid_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int t;
   bit order[$];
   bit exp_order[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      rst = 1'b1;
      a_if_req = 0; a_if_addr = '0; a_dm_req = 0; a_dm_we = 0; a_dm_addr = '0; a_dm_wdata = '0;
      b_if_req = 0; b_if_addr = '0; b_dm_req = 0; b_dm_we = 0; b_dm_addr = '0; b_dm_wdata = '0;
      step();
      step();
      // reset state
      chk("rst_a_ctrl", {a_if_gnt, a_if_rvalid, a_dm_gnt, a_dm_rvalid, a_mem_en, a_mem_we, a_busy}, 0);
      chk("rst_a_data", {a_if_rdata, a_dm_rdata}, 0);
      chk("rst_a_mem", {a_mem_addr, a_mem_wdata}, 0);
      chk("rst_b_ctrl", {b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid, b_mem_en, b_mem_we, b_busy}, 0);
      rst = 1'b0;
      step();

      // 1: IF read, RD_LAT=1
      a_if_req = 1; a_if_addr = 10'h010; t = cyc;
      sb_a.push_back('{1'b0, 32'hDEADBEEF, t + 3});
      step();
      chk("t1_gnt", {a_if_gnt, a_dm_gnt, a_busy, a_mem_en, a_mem_we}, 5'b10110);
      chk("t1_mem_addr", a_mem_addr, 10'h010);
      a_if_req = 0;
      step();
      chk("t1_wait", {a_if_gnt, a_mem_en, a_busy, a_if_rvalid}, 4'b0010);
      step();
      chk("t1_resp", {a_busy, a_if_rvalid, a_dm_rvalid}, 3'b110);
      chk("t1_rdata", a_if_rdata, 32'hDEADBEEF);
      step();
      chk("t1_idle", {a_busy, a_if_rvalid}, 2'b00);

      // 2: DM write
      a_dm_req = 1; a_dm_we = 1; a_dm_addr = 10'h3FF; a_dm_wdata = 32'h12345678;
      step();
      chk("t2_gnt", {a_dm_gnt, a_if_gnt, a_mem_en, a_mem_we}, 4'b1011);
      chk("t2_mem_addr", a_mem_addr, 10'h3FF);
      chk("t2_mem_wdata", a_mem_wdata, 32'h12345678);
      a_dm_req = 0; a_dm_we = 0;
      step();
      chk("t2_idle", {a_busy, a_dm_rvalid, a_mem_en}, 3'b000);
      chk("t2_addr_hold", a_mem_addr, 10'h3FF);
      step();
      step();

      // 3: both held high -> streak-limited grant order
      a_if_addr = 10'h020; a_dm_we = 1; a_dm_addr = 10'h100; a_dm_wdata = 32'h0000_00AA;
      sb_a.push_back('{1'b0, mval(10'h020), -1});
      sb_a.push_back('{1'b0, mval(10'h020), -1});
      a_if_req = 1; a_dm_req = 1;
      for (int k = 0; k < 200; k++) begin
         step();
         if (a_if_gnt) order.push_back(1'b0);
         if (a_dm_gnt) order.push_back(1'b1);
         if (order.size() >= 10) break;
      end
      a_if_req = 0; a_dm_req = 0; a_dm_we = 0;
      chk("t3_grant_count", order.size(), 10);
      for (int i = 0; i < 10; i++) begin
         if (i < order.size()) chk($sformatf("t3_grant_%0d", i), order[i], exp_order[i]);
      end
      for (int k = 0; k < 20 && a_busy; k++) step();
      chk("t3_drained", a_busy, 0);
      step();

      // 6: DM read, then IF read must not disturb dm_rdata
      a_dm_req = 1; a_dm_we = 0; a_dm_addr = 10'h005; t = cyc;
      sb_a.push_back('{1'b1, mval(10'h005), t + 3});
      step();
      chk("t6_dm_gnt", a_dm_gnt, 1);
      a_dm_req = 0;
      step(); step(); step();
      a_if_req = 1; a_if_addr = 10'h010; t = cyc;
      sb_a.push_back('{1'b0, 32'hDEADBEEF, t + 3});
      step();
      a_if_req = 0;
      step(); step();
      chk("t6_rvalids", {a_if_rvalid, a_dm_rvalid}, 2'b10);
      chk("t6_dm_rdata_hold", a_dm_rdata, mval(10'h005));
      step();

      // 5: reset during WAIT of an IF read
      a_if_req = 1; a_if_addr = 10'h030;
      step();
      chk("t5_gnt", a_if_gnt, 1);
      a_if_req = 0;
      step();
      chk("t5_in_wait", {a_busy, a_mem_en}, 2'b10);
      rst = 1'b1;
      step();
      chk("t5_rst_ctrl", {a_if_gnt, a_if_rvalid, a_dm_gnt, a_dm_rvalid, a_mem_en, a_mem_we, a_busy}, 0);
      chk("t5_rst_if_rdata", a_if_rdata, 0);
      chk("t5_rst_dm_rdata", a_dm_rdata, 0);
      chk("t5_rst_mem", {a_mem_addr, a_mem_wdata}, 0);
      rst = 1'b0;
      step();
      chk("t5_no_rvalid", a_if_rvalid, 0);
      a_if_req = 1; a_if_addr = 10'h040; t = cyc;
      sb_a.push_back('{1'b0, mval(10'h040), t + 3});
      step();
      chk("t5_regnt", a_if_gnt, 1);
      a_if_req = 0;
      step(); step();
      chk("t5_rvalid", a_if_rvalid, 1);
      step();

      // 4: RD_LAT=3 back-to-back DM reads
      b_dm_req = 1; b_dm_we = 0; b_dm_addr = 10'h001; t = cyc;
      sb_b.push_back('{1'b1, mval(10'h001), t + 5});
      sb_b.push_back('{1'b1, mval(10'h002), t + 11});
      step();
      chk("t4_gnt1", b_dm_gnt, 1);
      b_dm_addr = 10'h002;
      for (int k = 2; k <= 12; k++) begin
         step();
         if (k == 7) begin
            chk("t4_gnt2", b_dm_gnt, 1);
            b_dm_req = 0;
         end
         if (k >= 6 && k <= 10) chk($sformatf("t4_hold_%0d", k), b_dm_rdata, mval(10'h001));
      end
      chk("t4_final_rdata", b_dm_rdata, mval(10'h002));
      chk("t4_idle", b_busy, 0);

      step(); step();
      chk("sb_a_empty", sb_a.size(), 0);
      chk("sb_b_empty", sb_b.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
